// File: rtl/demux_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : demux_dispatch_if
//  Description : Handshake bundle between the packet source, demux_dispatch
//                and the downstream 4-way demultiplexer.
//                master : packet source / downstream sink (drives in_*,
//                         out_ready; observes everything else)
//                slave  : demux_dispatch (accepts in_*, drives A/S/out_*,
//                         hdr_err and the per-channel packet counters)
//  Revision    : 1.0  initial release
// ============================================================================
interface demux_dispatch_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] A;
  logic [1:0] S;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       hdr_err;
  logic [7:0] pkt_cnt0;
  logic [7:0] pkt_cnt1;
  logic [7:0] pkt_cnt2;
  logic [7:0] pkt_cnt3;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, A, S, out_valid, out_last, hdr_err,
    input  pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, A, S, out_valid, out_last, hdr_err,
    output pkt_cnt0, pkt_cnt1, pkt_cnt2, pkt_cnt3
  );
endinterface
`default_nettype wire

// File: rtl/demux_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : demux_dispatch
//  Description : Header-framed packet dispatcher for a 4-way 8-bit demux.
//                Header byte = {chan[1:0], reserved[1:0], len[3:0]}; payload
//                bytes are presented on registered A with channel select S.
//                Headers with nonzero reserved bits pulse hdr_err and their
//                payload is swallowed.
//  Ports       : clk, rst (sync, active-high)
//                bus.in_data/in_valid/in_ready   upstream byte stream
//                bus.A/S/out_valid/out_ready/out_last  registered output
//                bus.hdr_err                     1-cycle bad-header pulse
//                bus.pkt_cnt0..3                 delivered packets/channel
//  Option      : DISPATCH_STATS_EN enables the per-channel packet counters;
//                when undefined the counters read as 8'h00.
//  Revision    : 1.0  initial release
// ============================================================================
module demux_dispatch (
  input  wire logic          clk,
  input  wire logic          rst,
  demux_dispatch_if.slave    bus
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;

  logic [1:0] state_q, state_d;
  logic [3:0] rem_q,   rem_d;
  logic [1:0] chan_q,  chan_d;
  logic [7:0] a_q,     a_d;
  logic [1:0] s_q,     s_d;
  logic       ov_q,    ov_d;
  logic       last_q,  last_d;
  logic       err_q,   err_d;

  logic       w_in_ready;
  logic       w_accept;
  logic       w_load;

  // Only PAYLOAD can back-pressure: it needs a free (or draining) output slot.
  always_comb begin
    w_in_ready = 1'b0;
    if (!rst) begin
      if (state_q == ST_PAYLOAD) w_in_ready = !ov_q || bus.out_ready;
      else                       w_in_ready = 1'b1;
    end
  end

  assign w_accept = bus.in_valid && w_in_ready;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    chan_d  = chan_q;
    err_d   = 1'b0;
    w_load  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          chan_d = bus.in_data[7:6];
          rem_d  = bus.in_data[3:0];
          if (bus.in_data[5:4] != 2'b00) begin
            err_d = 1'b1;
            if (bus.in_data[3:0] != 4'd0) state_d = ST_DROP;
          end else if (bus.in_data[3:0] != 4'd0) begin
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_accept) begin
          w_load = 1'b1;
          rem_d  = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (w_accept) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output slot: a new load wins over a drain, so back-to-back bytes keep
  // out_valid high; without a load the registers hold and only valid drops.
  always_comb begin
    a_d    = a_q;
    s_d    = s_q;
    last_d = last_q;
    ov_d   = ov_q;
    if (w_load) begin
      a_d    = bus.in_data;
      s_d    = chan_q;
      last_d = (rem_q == 4'd1);
      ov_d   = 1'b1;
    end else if (ov_q && bus.out_ready) begin
      ov_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rem_q   <= 4'd0;
      chan_q  <= 2'b00;
      a_q     <= 8'h00;
      s_q     <= 2'b00;
      ov_q    <= 1'b0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      chan_q  <= chan_d;
      a_q     <= a_d;
      s_q     <= s_d;
      ov_q    <= ov_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.A         = a_q;
  assign bus.S         = s_q;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = last_q;
  assign bus.hdr_err   = err_q;

`ifdef DISPATCH_STATS_EN
  logic [7:0] cnt_q [4];

  // A packet counts as delivered when its last byte leaves the output slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'h00;
    end else if (ov_q && bus.out_ready && last_q) begin
      cnt_q[s_q] <= cnt_q[s_q] + 8'd1;
    end
  end

  assign bus.pkt_cnt0 = cnt_q[0];
  assign bus.pkt_cnt1 = cnt_q[1];
  assign bus.pkt_cnt2 = cnt_q[2];
  assign bus.pkt_cnt3 = cnt_q[3];
`else
  assign bus.pkt_cnt0 = 8'h00;
  assign bus.pkt_cnt1 = 8'h00;
  assign bus.pkt_cnt2 = 8'h00;
  assign bus.pkt_cnt3 = 8'h00;
`endif

endmodule
`default_nettype wire

// File: tb/tb_demux_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_demux_dispatch
//  Description : Self-checking bench for demux_dispatch: per-cycle vector
//                table for the directed packet scenarios, a randomized packet
//                stream checked against a queue-based packet model, and a
//                reset-mid-packet sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_demux_dispatch;

`ifdef DISPATCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  demux_dispatch_if bus ();
  demux_dispatch dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] model_cnt [4];

  typedef struct {
    logic [7:0] d; logic v; logic ordy;
    logic e_rdy; logic e_ov; logic [7:0] e_a; logic [1:0] e_s; logic e_last; logic e_err;
  } vec_t;
  typedef struct { logic [7:0] d; bit hdr; } sb_t;
  typedef struct { logic [7:0] a; logic [1:0] s; logic last; } ob_t;

  vec_t tv[$];
  sb_t  stream[$];
  ob_t  exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic void addv(input logic [7:0] d, input logic v, input logic o,
                               input logic rdy, input logic ov, input logic [7:0] a,
                               input logic [1:0] s, input logic last, input logic err);
    vec_t x;
    x.d = d; x.v = v; x.ordy = o; x.e_rdy = rdy; x.e_ov = ov;
    x.e_a = a; x.e_s = s; x.e_last = last; x.e_err = err;
    tv.push_back(x);
  endfunction

  function automatic logic [7:0] cnt_of(input int c);
    case (c)
      0: return bus.pkt_cnt0;
      1: return bus.pkt_cnt1;
      2: return bus.pkt_cnt2;
      default: return bus.pkt_cnt3;
    endcase
  endfunction

  task automatic drive(input logic [7:0] d, input logic v, input logic o);
    @(negedge clk);
    bus.in_data = d; bus.in_valid = v; bus.out_ready = o;
    #1;
  endtask

  task automatic chk_counters(input string nm);
    for (int c = 0; c < 4; c++)
      chk($sformatf("%s cnt%0d", nm, c), {24'd0, cnt_of(c)}, {24'd0, STATS ? model_cnt[c] : 8'h00});
  endtask

  initial begin
    logic exp_err_next;
    int   idx;
    int   cyc;
    bit   v;

    for (int c = 0; c < 4; c++) model_cnt[c] = 8'h00;
    rst = 1'b1; bus.in_data = 8'h00; bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // ---------------- reset state ----------------
    repeat (2) @(negedge clk);
    #1 chk("rst in_ready", {31'd0, bus.in_ready}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rst out_valid", {31'd0, bus.out_valid}, 0);
    chk("rst A",         {24'd0, bus.A}, 0);
    chk("rst S",         {30'd0, bus.S}, 0);
    chk("rst out_last",  {31'd0, bus.out_last}, 0);
    chk("rst hdr_err",   {31'd0, bus.hdr_err}, 0);
    chk("rst in_ready1", {31'd0, bus.in_ready}, 1);
    chk_counters("rst");

    // ---------------- directed vector table ----------------
    // Expected values are what is visible while the row's inputs are applied.
    // chan 2, L=3, free-flowing
    addv(8'h83,1,1, 1,0,8'h00,0,0,0);
    addv(8'h11,1,1, 1,0,8'h00,0,0,0);
    addv(8'h22,1,1, 1,1,8'h11,2,0,0);
    addv(8'h33,1,1, 1,1,8'h22,2,0,0);
    addv(8'h00,0,1, 1,1,8'h33,2,1,0);
    addv(8'h00,0,1, 1,0,8'h00,0,0,0);
    // same packet, 3-cycle downstream stall after first byte
    addv(8'h83,1,1, 1,0,8'h00,0,0,0);
    addv(8'h11,1,1, 1,0,8'h00,0,0,0);
    addv(8'h22,1,0, 0,1,8'h11,2,0,0);
    addv(8'h22,1,0, 0,1,8'h11,2,0,0);
    addv(8'h22,1,0, 0,1,8'h11,2,0,0);
    addv(8'h22,1,1, 1,1,8'h11,2,0,0);
    addv(8'h33,1,1, 1,1,8'h22,2,0,0);
    addv(8'h00,0,1, 1,1,8'h33,2,1,0);
    addv(8'h00,0,1, 1,0,8'h00,0,0,0);
    // bad header 0x92 with two dropped bytes, then 0x01,CC
    addv(8'h92,1,1, 1,0,8'h00,0,0,0);
    addv(8'hAA,1,1, 1,0,8'h00,0,0,1);
    addv(8'hBB,1,1, 1,0,8'h00,0,0,0);
    addv(8'h01,1,1, 1,0,8'h00,0,0,0);
    addv(8'hCC,1,1, 1,0,8'h00,0,0,0);
    addv(8'h00,0,1, 1,1,8'hCC,0,1,0);
    addv(8'h00,0,1, 1,0,8'h00,0,0,0);
    // header-only 0xC0, then 0x41,5A
    addv(8'hC0,1,1, 1,0,8'h00,0,0,0);
    addv(8'h41,1,1, 1,0,8'h00,0,0,0);
    addv(8'h5A,1,1, 1,0,8'h00,0,0,0);
    addv(8'h00,0,1, 1,1,8'h5A,1,1,0);
    addv(8'h00,0,1, 1,0,8'h00,0,0,0);
    // back-to-back single-byte packets on chan 0 and chan 3
    addv(8'h01,1,1, 1,0,8'h00,0,0,0);
    addv(8'h77,1,1, 1,0,8'h00,0,0,0);
    addv(8'hC1,1,1, 1,1,8'h77,0,1,0);
    addv(8'h88,1,1, 1,0,8'h00,0,0,0);
    addv(8'h00,0,1, 1,1,8'h88,3,1,0);
    addv(8'h00,0,1, 1,0,8'h00,0,0,0);

    foreach (tv[i]) begin
      drive(tv[i].d, tv[i].v, tv[i].ordy);
      chk($sformatf("vec%0d in_ready", i),  {31'd0, bus.in_ready},  {31'd0, tv[i].e_rdy});
      chk($sformatf("vec%0d out_valid", i), {31'd0, bus.out_valid}, {31'd0, tv[i].e_ov});
      chk($sformatf("vec%0d hdr_err", i),   {31'd0, bus.hdr_err},   {31'd0, tv[i].e_err});
      if (tv[i].e_ov)
        chk($sformatf("vec%0d A/S/last", i), {21'd0, bus.A, bus.S, bus.out_last},
            {21'd0, tv[i].e_a, tv[i].e_s, tv[i].e_last});
    end
    model_cnt[0] = 8'd2; model_cnt[1] = 8'd1; model_cnt[2] = 8'd2; model_cnt[3] = 8'd1;
    drive(8'h00, 1'b0, 1'b1);
    chk_counters("table");

    // ---------------- randomized packet stream ----------------
    for (int p = 0; p < 60; p++) begin
      logic [1:0] ch;
      logic [1:0] rsv;
      logic [3:0] len;
      ch  = 2'($urandom_range(0, 3));
      rsv = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      len = 4'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) len = 4'd15;
      stream.push_back('{d: {ch, rsv, len}, hdr: 1'b1});
      for (int b = 0; b < len; b++) begin
        logic [7:0] pb;
        pb = 8'($urandom);
        stream.push_back('{d: pb, hdr: 1'b0});
        if (rsv == 2'b00) exp_q.push_back('{a: pb, s: ch, last: (b == len - 1)});
      end
      if (rsv == 2'b00 && len != 0) model_cnt[ch] = model_cnt[ch] + 8'd1;
    end

    idx = 0; cyc = 0; exp_err_next = 1'b0;
    while ((idx < stream.size() || exp_q.size() > 0) && cyc < 5000) begin
      cyc++;
      @(negedge clk);
      v = (idx < stream.size()) && ($urandom_range(0, 3) != 0);
      bus.in_valid  = v;
      bus.in_data   = v ? stream[idx].d : 8'($urandom);
      bus.out_ready = (idx >= stream.size()) || ($urandom_range(0, 2) != 0);
      #1;
      chk("rand hdr_err", {31'd0, bus.hdr_err}, {31'd0, exp_err_next});
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("rand spurious out_valid", {31'd0, bus.out_valid}, 0);
        end else begin
          chk("rand A/S/last", {21'd0, bus.A, bus.S, bus.out_last},
              {21'd0, exp_q[0].a, exp_q[0].s, exp_q[0].last});
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      exp_err_next = v && bus.in_ready && stream[idx].hdr && (stream[idx].d[5:4] != 2'b00);
      if (v && bus.in_ready) idx++;
    end
    chk("rand timeout", cyc, (cyc >= 5000) ? 0 : cyc);
    drive(8'h00, 1'b0, 1'b1);
    chk("rand drained", {31'd0, bus.out_valid}, 0);
    chk_counters("rand");

    // ---------------- reset in the middle of a packet ----------------
    drive(8'h44, 1'b1, 1'b1);
    drive(8'h01, 1'b1, 1'b1);
    drive(8'h02, 1'b1, 1'b1);
    @(negedge clk); rst = 1'b1; bus.in_valid = 1'b0; #1;
    chk("midrst in_ready", {31'd0, bus.in_ready}, 0);
    @(negedge clk); rst = 1'b0; #1;
    for (int c = 0; c < 4; c++) model_cnt[c] = 8'h00;
    chk("midrst out_valid", {31'd0, bus.out_valid}, 0);
    chk("midrst A/S/last",  {21'd0, bus.A, bus.S, bus.out_last}, 0);
    chk("midrst in_ready1", {31'd0, bus.in_ready}, 1);
    chk_counters("midrst");
    drive(8'h41, 1'b1, 1'b1);
    drive(8'h99, 1'b1, 1'b1);
    chk("post hdr treated", {31'd0, bus.out_valid}, 0);
    drive(8'h00, 1'b0, 1'b1);
    chk("post A/S/last", {21'd0, bus.A, bus.S, bus.out_last}, {21'd0, 8'h99, 2'b01, 1'b1});
    chk("post out_valid", {31'd0, bus.out_valid}, 1);
    drive(8'h00, 1'b0, 1'b1);
    model_cnt[1] = 8'd1;
    chk("post out_valid0", {31'd0, bus.out_valid}, 0);
    chk_counters("post");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
